// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared RV32I definitions for the program loader and the core's main decoder:
//   loader command kinds, base opcodes, fixed/branch funct3 values, loader FSM
//   state type and a signed-range helper used for immediate legality checks.
package riscv_pkg;

  typedef enum logic [3:0] {
    KIND_LW    = 4'd0,
    KIND_SW    = 4'd1,
    KIND_R     = 4'd2,
    KIND_BEQ   = 4'd3,
    KIND_BNE   = 4'd4,
    KIND_BLT   = 4'd5,
    KIND_BGE   = 4'd6,
    KIND_IALU  = 4'd7,
    KIND_JAL   = 4'd8,
    KIND_JALR  = 4'd9,
    KIND_LUI   = 4'd10,
    KIND_AUIPC = 4'd11
  } cmd_kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SRX  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2
  } loader_state_e;

  // True when v, read as two's complement, fits in a 'bits'-wide signed field:
  // every bit from bits-1 upward must equal the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = bits - 1; i < 32; i++) begin
      if (v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// instr_encoder
//   Combinational packer: one decoded loader command -> one RV32I word.
//   Ports:
//     kind, funct3, f7b5, rd, rs1, rs2, imm : command fields (see riscv_pkg kinds)
//     word    : packed 32-bit instruction
//     illegal : kind unknown or immediate not encodable for the kind
module instr_encoder
  import riscv_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [2:0] br_f3;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    br_f3   = F3_BEQ;
    case (kind)
      KIND_LW: begin
        word    = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
        illegal = !fits_signed(imm, 12);
      end
      KIND_SW: begin
        word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
        illegal = !fits_signed(imm, 12);
      end
      KIND_R: begin
        word = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, OP_OP};
      end
      KIND_BEQ, KIND_BNE, KIND_BLT, KIND_BGE: begin
        case (kind)
          KIND_BNE: br_f3 = F3_BNE;
          KIND_BLT: br_f3 = F3_BLT;
          KIND_BGE: br_f3 = F3_BGE;
          default:  br_f3 = F3_BEQ;
        endcase
        word    = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], OP_BRANCH};
        illegal = !fits_signed(imm, 13) || imm[0];
      end
      KIND_IALU: begin
        // Shift-immediates carry funct7 in the upper immediate bits.
        if (funct3 == F3_SLL || funct3 == F3_SRX)
          word = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OP_IMM};
        else
          word = {imm[11:0], rs1, funct3, rd, OP_IMM};
        illegal = !fits_signed(imm, 12);
      end
      KIND_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        illegal = !fits_signed(imm, 21) || imm[0];
      end
      KIND_JALR: begin
        word    = {imm[11:0], rs1, F3_JALR, rd, OP_JALR};
        illegal = !fits_signed(imm, 12);
      end
      KIND_LUI: begin
        word    = {imm[31:12], rd, OP_LUI};
        illegal = (imm[11:0] != 12'h000);
      end
      KIND_AUIPC: begin
        word    = {imm[31:12], rd, OP_AUIPC};
        illegal = (imm[11:0] != 12'h000);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Accepts decoded instruction commands over valid/ready, packs them into RV32I
//   words and writes them to sequential instruction-memory addresses.
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     load_start, load_end  : open / close a load session (pulses)
//     cmd_*                 : command handshake and fields
//     imem_we/waddr/wdata   : one-cycle instruction-memory write
//     loading, full, err    : session open, memory full, sticky illegal-command flag
//     count                 : words written in the current session
module imem_program_loader
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_end,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_kind,
  input  logic [2:0]    cmd_funct3,
  input  logic          cmd_f7b5,
  input  logic [4:0]    cmd_rd,
  input  logic [4:0]    cmd_rs1,
  input  logic [4:0]    cmd_rs2,
  input  logic [31:0]   cmd_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          loading,
  output logic          full,
  output logic          err,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

  loader_state_e state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic [31:0]   word_q, word_d;
  logic          end_q, end_d;

  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          is_full;
  logic          handshake;

  instr_encoder u_encoder (
    .kind    (cmd_kind),
    .funct3  (cmd_funct3),
    .f7b5    (cmd_f7b5),
    .rd      (cmd_rd),
    .rs1     (cmd_rs1),
    .rs2     (cmd_rs2),
    .imm     (cmd_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign is_full   = (count_q == FULL_COUNT);
  assign cmd_ready = (state_q == S_ACCEPT) && !is_full;
  assign handshake = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    count_d = count_q;
    err_d   = err_q;
    word_d  = word_q;
    end_d   = end_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_ACCEPT;
          waddr_d = '0;
          count_d = '0;
          err_d   = 1'b0;
          end_d   = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (load_start) begin
          waddr_d = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
        if (handshake && enc_illegal) begin
          err_d = 1'b1;
          if (load_end) state_d = S_IDLE;
        end else if (handshake) begin
          // load_end alongside a handshake is remembered so the session
          // closes only after this word has been written.
          word_d  = enc_word;
          end_d   = load_end;
          state_d = S_WRITE;
        end else if (load_end) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        end_d = 1'b0;
        if (load_start) begin
          // The strobe for the pending word is already out this cycle;
          // the restart takes effect on the following one.
          state_d = S_ACCEPT;
          waddr_d = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          count_d = count_q + 1'b1;
          // Hold at the last address instead of wrapping; full blocks further writes.
          waddr_d = (waddr_q == LAST_ADDR) ? waddr_q : waddr_q + 1'b1;
          state_d = (end_q || load_end) ? S_IDLE : S_ACCEPT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
      err_q   <= err_d;
      word_q  <= word_d;
      end_q   <= end_d;
    end
  end

  assign imem_we    = (state_q == S_WRITE);
  assign imem_waddr = waddr_q;
  assign imem_wdata = word_q;
  assign loading    = (state_q != S_IDLE);
  assign full       = is_full;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader
//   Scoreboard bench: the driver pushes the expected (address, word, cycle) of every
//   accepted legal command; a negedge monitor pops and compares on each imem_we.
module tb_imem_program_loader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          reset, load_start, load_end, cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_kind;
  logic [2:0]    cmd_funct3;
  logic          cmd_f7b5;
  logic [4:0]    cmd_rd, cmd_rs1, cmd_rs2;
  logic [31:0]   cmd_imm;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          loading, full, err;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  imem_program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_funct3(cmd_funct3), .cmd_f7b5(cmd_f7b5), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .loading(loading), .full(full), .err(err), .count(count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   word;
    int unsigned   cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int          m_count;
  bit          m_err, m_loading;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit fits(input logic [31:0] v, input int n);
    longint s;
    s = longint'($signed(v));
    return (s >= -(longint'(1) << (n - 1))) && (s <= (longint'(1) << (n - 1)) - 1);
  endfunction

  function automatic bit ref_legal(input int kind, input logic [31:0] imm);
    case (kind)
      0, 1, 7, 9:  return fits(imm, 12);
      2:           return 1'b1;
      3, 4, 5, 6:  return fits(imm, 13) && (imm[0] == 1'b0);
      8:           return fits(imm, 21) && (imm[0] == 1'b0);
      10, 11:      return (imm & 32'hfff) == 0;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_encode(input int kind, input logic [2:0] f3, input logic f7b5,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] d, s1, s2, fn3, bf3;
    d   = 32'(rd) << 7;
    s1  = 32'(rs1) << 15;
    s2  = 32'(rs2) << 20;
    fn3 = 32'(f3) << 12;
    case (kind)
      0: return ((imm & 32'hfff) << 20) | s1 | (32'd2 << 12) | d | 32'h03;
      1: return (((imm >> 5) & 32'h7f) << 25) | s2 | s1 | (32'd2 << 12) | ((imm & 32'h1f) << 7) | 32'h23;
      2: return (32'(f7b5) << 30) | s2 | s1 | fn3 | d | 32'h33;
      3, 4, 5, 6: begin
        case (kind)
          3: bf3 = 0;
          4: bf3 = 1;
          5: bf3 = 4;
          default: bf3 = 5;
        endcase
        return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | s2 | s1 | (bf3 << 12)
             | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      end
      7: begin
        if (f3 == 3'd1 || f3 == 3'd5)
          return (32'(f7b5) << 30) | ((imm & 32'h1f) << 20) | s1 | fn3 | d | 32'h13;
        return ((imm & 32'hfff) << 20) | s1 | fn3 | d | 32'h13;
      end
      8: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 32'h1) << 20)
              | (((imm >> 12) & 32'hff) << 12) | d | 32'h6f;
      9:  return ((imm & 32'hfff) << 20) | s1 | d | 32'h67;
      10: return (imm & 32'hfffff000) | d | 32'h37;
      11: return (imm & 32'hfffff000) | d | 32'h17;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(input int kind);
    if ($urandom_range(0, 3) == 0) return $urandom;
    case (kind)
      0, 1, 7, 9:  return 32'(int'($urandom_range(0, 4095)) - 2048);
      3, 4, 5, 6:  return 32'(int'($urandom_range(0, 8191)) - 4096) & ~32'h1;
      8:           return 32'(int'($urandom_range(0, 2097151)) - 1048576) & ~32'h1;
      10, 11:      return $urandom & 32'hfffff000;
      default:     return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected", imem_waddr, imem_wdata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 64'(imem_waddr), 64'(e.addr));
        check("wr_data", 64'(imem_wdata), 64'(e.word));
        check("wr_count", 64'(count), 64'(e.addr));
        check("wr_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int kind, input logic [2:0] f3, input logic f7b5, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] exp_word, input bit with_end);
    bit   legal;
    int   t;
    exp_t e;
    legal = ref_legal(kind, imm);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = 4'(kind); cmd_funct3 = f3; cmd_f7b5 = f7b5;
    cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (cmd_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: cmd_ready %b after 20 cycles, expected 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    load_end = with_end;
    if (legal) begin
      e.addr = AW'(m_count);
      e.word = exp_word;
      e.cyc  = cyc + 1;
      sb.push_back(e);
      m_count++;
    end else begin
      m_err = 1'b1;
    end
    if (with_end) m_loading = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    load_end  = 1'b0;
  endtask

  task automatic send_model(input int kind, input logic [2:0] f3, input logic f7b5, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    send(kind, f3, f7b5, rd, rs1, rs2, imm, ref_encode(kind, f3, f7b5, rd, rs1, rs2, imm), 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    m_count = 0; m_err = 1'b0; m_loading = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"},   64'(count),   64'(m_count));
    check({tag, "_err"},     64'(err),     64'(m_err));
    check({tag, "_loading"}, 64'(loading), 64'(m_loading));
    check({tag, "_full"},    64'(full),    64'(m_count == DEPTH));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    64'(imem_we),    64'd0);
    check({tag, "_waddr"}, 64'(imem_waddr), 64'd0);
    check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_state"}, 64'({loading, full, err, cmd_ready}), 64'd0);
    check({tag, "_count"}, 64'(count),      64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_start = 1'b0; load_end = 1'b0; cmd_valid = 1'b0;
    cmd_kind = '0; cmd_funct3 = '0; cmd_f7b5 = 1'b0;
    cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    m_count = 0; m_err = 1'b0; m_loading = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Directed encodings against known words.
    pulse_start();
    check_state("start");
    send(7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    @(negedge clk);
    check_state("addi");
    send(0, 3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd4, 32'h0040A103, 1'b0);
    send(1, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0);
    send(3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0);
    send(8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 32'h010000EF, 1'b0);
    send(10, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
    @(negedge clk);
    check_state("directed");

    // Illegal commands: dropped, err set, next legal one still written.
    send(3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 32'h0, 1'b0);
    @(negedge clk);
    check_state("beq_odd");
    send(13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0, 1'b0);
    send(7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h0, 1'b0);
    @(negedge clk);
    check_state("illegal");
    send_model(7, 3'd0, 1'b0, 5'd3, 5'd3, 5'd0, 32'd1);
    @(negedge clk);
    check_state("after_illegal");

    // load_start during WRITE: the pending word lands, then the session restarts.
    send_model(2, 3'd0, 1'b1, 5'd4, 5'd5, 5'd6, 32'd0);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    m_count = 0; m_err = 1'b0;
    check_state("restart_in_write");

    // Randomized commands, including illegal kinds and out-of-range immediates.
    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 13));
      send_model(k, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm(k));
      @(negedge clk);
      check_state("rand");
    end

    // Fill to DEPTH, then show no further acceptance.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      send_model(7, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'd0,
                 32'(int'($urandom_range(0, 4095)) - 2048));
    end
    @(negedge clk);
    check_state("filled");
    check("full_cmd_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_kind = 4'd7; cmd_imm = 32'd1;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    check_state("full_hold");
    pulse_start();
    check_state("refill_start");
    check("refill_waddr", 64'(imem_waddr), 64'd0);

    // load_end together with a handshake: word written, then session closes.
    send_model(9, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8);
    send(0, 3'd0, 1'b0, 5'd7, 5'd8, 5'd0, 32'hFFFFF800,
         ref_encode(0, 3'd0, 1'b0, 5'd7, 5'd8, 5'd0, 32'hFFFFF800), 1'b1);
    @(negedge clk);
    check_state("end_with_cmd");

    // Reset asserted while imem_we is high: everything returns to zero.
    pulse_start();
    send_model(11, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'hABCDE000);
    reset = 1'b1;
    @(negedge clk);
    m_count = 0; m_err = 1'b0; m_loading = 1'b0;
    check_all_zero("reset_in_write");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_state("after_reset");

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
